// File: rtl/mux_tree_pkg.sv
// Shared sizing helpers for the pipelined mux tree: select width, padded leaf
// count, pipeline latency and register placement.
package mux_tree_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A 1-channel-bit select is still needed when CHANNELS <= 2.
  function automatic int sel_width(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

  function automatic int leaf_count(input int channels);
    return 1 << sel_width(channels);
  endfunction

  function automatic int latency(input int channels, input int reg_stride);
    return (sel_width(channels) + reg_stride - 1) / reg_stride;
  endfunction

  function automatic bit level_registered(input int k, input int levels, input int reg_stride);
    return (((k + 1) % reg_stride) == 0) || (k == levels - 1);
  endfunction

endpackage

// File: rtl/mux_tree_level.sv
// One level of the mux tree: pairs of entries reduced by select bit LVL,
// optionally registered together with the valid/sel/err sideband.
module mux_tree_level #(
  parameter int W          = 1,
  parameter int N_IN       = 2,
  parameter int SELW       = 1,
  parameter int LVL        = 0,
  parameter bit REGISTERED = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    data_en,
  input  logic [N_IN*W-1:0]       in_data,
  input  logic [SELW-1:0]         in_sel,
  input  logic                    in_err,
  input  logic                    in_valid,
  output logic [(N_IN/2)*W-1:0]   out_data,
  output logic [SELW-1:0]         out_sel,
  output logic                    out_err,
  output logic                    out_valid
);

  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*W-1:0] mux_data;

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N_OUT; i++) begin
      mux_data[i*W +: W] = in_sel[LVL] ? in_data[(2*i+1)*W +: W] : in_data[(2*i)*W +: W];
    end
  end

  if (REGISTERED) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid <= 1'b0;
        out_sel   <= '0;
      end else if (en) begin
        out_valid <= in_valid;
        out_sel   <= in_sel;
      end
    end

    // Data may have a narrower enable than valid so the output can hold its last beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_data <= '0;
        out_err  <= 1'b0;
      end else if (data_en) begin
        out_data <= mux_data;
        out_err  <= in_err;
      end
    end
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, en, data_en};
    assign out_data  = mux_data;
    assign out_sel   = in_sel;
    assign out_err   = in_err;
    assign out_valid = in_valid;
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined CHANNELS:1 mux of WIDTH-bit channels built from a binary tree of
// 2:1 levels, with a global stall when the output is backpressured.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int  WIDTH      = 1,
  parameter int  CHANNELS   = 8,
  parameter int  REG_STRIDE = 1,
  localparam int SELW       = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]           in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_sel_err,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int LEVELS = SELW;
  localparam int LEAVES = leaf_count(CHANNELS);

  logic                    stall;
  logic                    in_fire;
  logic                    in_err;
  logic [LEAVES*WIDTH-1:0] leaf;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign in_fire  = in_valid && in_ready;
  assign in_err   = 32'(in_sel) >= CHANNELS;

  // Out-of-range selects land on zero-padded leaves, which yields the zero data.
  always_comb begin
    leaf = '0;
    leaf[CHANNELS*WIDTH-1:0] = in_data;
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int N_IN  = LEAVES >> k;
    localparam int N_OUT = N_IN / 2;
    localparam bit REG   = level_registered(k, LEVELS, REG_STRIDE);

    logic [N_IN*WIDTH-1:0]  d_in;
    logic [SELW-1:0]        s_in;
    logic                   e_in;
    logic                   v_in;
    logic [N_OUT*WIDTH-1:0] d;
    logic [SELW-1:0]        s;
    logic                   e;
    logic                   v;
    logic                   data_en;

    if (k == 0) begin : g_src
      assign d_in = leaf;
      assign s_in = in_sel;
      assign e_in = in_err;
      assign v_in = in_fire;
    end else begin : g_chain
      assign d_in = g_lvl[k-1].d;
      assign s_in = g_lvl[k-1].s;
      assign e_in = g_lvl[k-1].e;
      assign v_in = g_lvl[k-1].v;
    end

    if (k == LEVELS - 1) begin : g_last_en
      assign data_en = !stall && v_in;
    end else begin : g_mid_en
      assign data_en = !stall;
    end

    mux_tree_level #(
      .W          (WIDTH),
      .N_IN       (N_IN),
      .SELW       (SELW),
      .LVL        (k),
      .REGISTERED (REG)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (!stall),
      .data_en   (data_en),
      .in_data   (d_in),
      .in_sel    (s_in),
      .in_err    (e_in),
      .in_valid  (v_in),
      .out_data  (d),
      .out_sel   (s),
      .out_err   (e),
      .out_valid (v)
    );
  end

  logic unused_sel;
  assign unused_sel = ^g_lvl[LEVELS-1].s;

  assign out_data    = g_lvl[LEVELS-1].d;
  assign out_sel_err = g_lvl[LEVELS-1].e;
  assign out_valid   = g_lvl[LEVELS-1].v;

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 multiplexer of WIDTH-bit channels.
- Built as a binary tree of 2:1 mux levels, with pipeline registers inserted every REG_STRIDE levels.
- Valid/ready handshake on input and output, with a global stall on backpressure.
- Generalises the single-bit 2:1 mux test case to multi-channel, multi-bit, registered operation; used as a verification target and as a datapath mux in GateMate designs.

Parameters:
- WIDTH, 1, bits per channel (>=1).
- CHANNELS, 8, number of input channels (>=2; need not be a power of two).
- REG_STRIDE, 1, number of mux levels between pipeline registers (>=1). The output is always registered.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- in_sel  in  SELW  channel select; SELW = max(1, clog2(CHANNELS)).
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- out_data  out  WIDTH  selected channel data.
- out_sel_err  out  1  set when in_sel >= CHANNELS for this beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valid bits, data and sel_err registers clear to 0.
  - out_valid=0, out_data=0, out_sel_err=0.
  - in_ready=1 combinationally, since stall=0.
- Tree structure:
  - LEVELS = SELW.
  - Level k (0-based, nearest the inputs) uses select bit k. Unused leaves are padded with zero.
  - Remaining select bits and the sel_err flag travel with the data through every register stage.
- Pipeline register placement and latency:
  - A register follows level k when (k+1) % REG_STRIDE == 0, or when k = LEVELS-1.
  - LATENCY = ceil(LEVELS / REG_STRIDE) cycles, from accepted input to out_valid.
  - Example: CHANNELS=8, REG_STRIDE=1 gives LATENCY=3; REG_STRIDE=3 gives LATENCY=1.
- Stall:
  - stall = out_valid && !out_ready.
  - When stall=1, every stage register holds; in_ready = !stall.
  - No bubble collapsing: full throughput of 1 beat/cycle when out_ready=1.
- Stage valid:
  - Stage 0 valid loads in_valid && in_ready.
  - Stage i loads the valid of stage i-1 when !stall.
  - Data registers load regardless of valid when !stall; the value of data in an invalid stage is don't-care, except out_data, which holds its last valid value.
- Out-of-range select: in_sel >= CHANNELS forces data to 0 and sets sel_err for that beat; the beat still flows through normally.
- Simultaneous events:
  - in_valid with stall=1: not accepted; the source must hold the beat.
  - out_ready rising in the same cycle as new input: both transfers occur.
- Reset mid-stream: all in-flight beats are discarded; no partial output.
- WIDTH and CHANNELS=2 degenerate case: a single level, LATENCY=1; behaviour matches a registered 2:1 mux.

Decomposition:
- Package mux_tree_pkg:
  - function clog2.
  - function latency(CHANNELS, REG_STRIDE).
  - localparam helpers for padded leaf count (2**SELW).
- Sub-module mux_tree_level: one tree level of 2:1 muxes, with parameter REGISTERED (0/1), stage enable, and valid/sel/err sideband pass-through.
- Top: generates LEVELS instances of mux_tree_level.

Test Plan:
1. Reset, then CHANNELS=8, WIDTH=4, REG_STRIDE=1, out_ready=1.
   - Stimulus: in_data channel c = c+3; stream sel 0..7 back-to-back.
   - Required: out_valid rises 3 cycles after the first accept; out_data = 3,4,...,10 on consecutive cycles; out_sel_err=0.
2. CHANNELS=5, sel=5,6,7.
   - Required: out_data=0, out_sel_err=1 for each beat.
   - Follow with sel=4, channel 4 = 0xA: out_data=0xA, out_sel_err=0.
3. Backpressure: stream 6 beats and hold out_ready=0 for 4 cycles once out_valid=1.
   - Required: in_ready=0 during the stall; out_data stable; all 6 beats emerge in order, none lost or duplicated.
4. REG_STRIDE=3, CHANNELS=8: LATENCY=1.
   - sel=6, channel 6 = 0x5: out_data=0x5 one cycle after accept.
5. Assert rst_n low for 1 cycle with 2 beats in flight.
   - Required: out_valid=0 immediately (asynchronous), no stale beat emerges afterwards, in_ready=1.
6. CHANNELS=2, WIDTH=1: exhaustive sweep of d0, d1, sel (8 combinations).
   - Required: out_data = sel ? d1 : d0, 1 cycle after accept.
